// File: rtl/radioberry_pkg.sv
// ============================================================================
// Module   : radioberry_pkg
// Brief    : Shared types and constants for the RX nibble streaming path.
//            The SYNC state only exists when RX_SYNC_NIBBLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package radioberry_pkg;

  localparam int          DEFAULT_SAMPLE_W = 48;
  localparam int          DEFAULT_BURST    = 1024;
  localparam logic [3:0]  SYNC_NIBBLE      = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef RX_SYNC_NIBBLE_EN
    ,
    ST_SYNC  = 2'd2
`endif
  } rx_state_t;

  // Nibble counter width; a one-nibble sample still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_burst_flag.sv
// ============================================================================
// Module   : rx_burst_flag
// Brief    : Registered "burst available" flag: high while the FIFO holds at
//            least BURST samples. No hysteresis, one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_burst_flag
  import radioberry_pkg::*;
#(
  parameter int BURST = DEFAULT_BURST,
  parameter int LVL_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             burst_flag
);

  localparam int unsigned c_burst = BURST;

  logic w_at_burst;
  logic r_flag;

  assign w_at_burst = (32'(fifo_level) >= c_burst);
  assign burst_flag = r_flag;

  // Register the threshold compare so the Pi sees a glitch-free level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= w_at_burst;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_nibble_streamer.sv
// ============================================================================
// Module   : rx_nibble_streamer
// Brief    : Pops I/Q samples from the RX FIFO and serializes them to the Pi
//            one nibble per clock, MSB nibble first, back-to-back when the
//            FIFO keeps up. Optional macro RX_SYNC_NIBBLE_EN inserts a 4'hA
//            marker nibble ahead of every sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_nibble_streamer
  import radioberry_pkg::*;
#(
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int BURST    = DEFAULT_BURST,
  parameter int LVL_W    = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [LVL_W-1:0]    fifo_level,
  output logic [3:0]          pi_rx_data,
  output logic                pi_rx_samples,
  output logic                underflow
);

  localparam int                 c_nib   = SAMPLE_W / 4;
  localparam int                 c_cnt_w = cnt_width(c_nib);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_nib - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [SAMPLE_W-1:0]   r_shreg;
  logic [SAMPLE_W-1:0]   w_shreg_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic [3:0]            r_data;
  logic [3:0]            w_data_nxt;
  logic                  r_underflow;
  logic                  w_uf_set;
  logic                  r_armed;
  logic                  w_ready;

  // What a fresh sample load puts into the datapath.
  rx_state_t             w_load_state;
  logic [3:0]            w_load_data;
  logic [SAMPLE_W-1:0]   w_load_shreg;

  logic [3:0]            w_top_nib;
  logic [SAMPLE_W-1:0]   w_shifted;

  assign w_top_nib = r_shreg[SAMPLE_W-1 -: 4];
  assign w_shifted = r_shreg << 4;

`ifdef RX_SYNC_NIBBLE_EN
  // Marker goes out first; the whole sample waits in the shift register.
  assign w_load_state = ST_SYNC;
  assign w_load_data  = SYNC_NIBBLE;
  assign w_load_shreg = s_tdata;
`else
  // First nibble goes straight to the output; the rest queue behind it.
  assign w_load_state = ST_SHIFT;
  assign w_load_data  = s_tdata[SAMPLE_W-1 -: 4];
  assign w_load_shreg = s_tdata << 4;
`endif

  assign s_tready      = w_ready;
  assign pi_rx_data    = r_data;
  assign underflow     = r_underflow;

  // State, shift register, nibble counter and output nibble registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_data      <= 4'h0;
      r_underflow <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data      <= w_data_nxt;
      r_underflow <= r_underflow | w_uf_set;
      // One idle edge after reset release before the first pop is allowed.
      r_armed     <= 1'b1;
    end
  end

  // Next-state logic; s_tready is only ever raised at a sample boundary
  // and only while s_tvalid is high, so at most one pop per sample period.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_ready     = 1'b0;
    w_uf_set    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_data_nxt = 4'h0;
        if (r_armed && s_tvalid) begin
          w_ready     = 1'b1;
          w_state_nxt = w_load_state;
          w_data_nxt  = w_load_data;
          w_shreg_nxt = w_load_shreg;
          w_cnt_nxt   = '0;
        end
      end

      ST_SHIFT: begin
        if (r_cnt == c_last) begin
          if (s_tvalid) begin
            w_ready     = 1'b1;
            w_state_nxt = w_load_state;
            w_data_nxt  = w_load_data;
            w_shreg_nxt = w_load_shreg;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_data_nxt  = 4'h0;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_uf_set    = 1'b1;
          end
        end else begin
          w_data_nxt  = w_top_nib;
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        end
      end

`ifdef RX_SYNC_NIBBLE_EN
      ST_SYNC: begin
        w_state_nxt = ST_SHIFT;
        w_data_nxt  = w_top_nib;
        w_shreg_nxt = w_shifted;
        w_cnt_nxt   = '0;
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
        w_data_nxt  = 4'h0;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  rx_burst_flag #(
    .BURST (BURST),
    .LVL_W (LVL_W)
  ) u_burst_flag (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_level (fifo_level),
    .burst_flag (pi_rx_samples)
  );

endmodule

`default_nettype wire

// File: doc/rx_nibble_streamer.md
RX_NIBBLE_STREAMER -- requirements
Module: rx_nibble_streamer

Interface
- REQ-001 SHALL have parameter SAMPLE_W, default 48, bits per I/Q sample (24 I + 24 Q); must be a multiple of 4.
- REQ-002 SHALL have parameter BURST, default 1024, number of buffered samples required before the Pi is told to read.
- REQ-003 SHALL have parameter LVL_W, default 11, width of the FIFO level input.
- REQ-004 clk  in  1  pi_rx_clk domain; single clock; every register is in this domain.
- REQ-005 rst_n  in  1  asynchronous, active-low reset.
- REQ-006 s_tdata  in  SAMPLE_W  sample from the RX FIFO; I occupies the upper half.
- REQ-007 s_tvalid  in  1  FIFO not empty.
- REQ-008 s_tready  out  1  pop strobe to the FIFO; high for one cycle per accepted sample.
- REQ-009 fifo_level  in  LVL_W  current RX FIFO occupancy.
- REQ-010 pi_rx_data  out  4  nibble to the Pi.
- REQ-011 pi_rx_samples  out  1  burst-available flag to the Pi.
- REQ-012 underflow  out  1  sticky flag: a sample boundary was reached with the FIFO empty while streaming.

Function
- REQ-013 SHALL implement a state machine with states IDLE, SHIFT (and SYNC when RX_SYNC_NIBBLE_EN is defined).
- REQ-014 IDLE: if s_tvalid, SHALL pulse s_tready and load s_tdata into the shift register, entering SYNC or SHIFT on the next cycle; otherwise stay in IDLE.
- REQ-015 SHIFT: SHALL drive one nibble per clk, MSB nibble first, for SAMPLE_W/4 cycles (12 at default).
- REQ-016 pi_rx_data SHALL be registered; the first nibble appears the cycle after the load.
- REQ-017 On the last nibble cycle with s_tvalid high, SHALL pulse s_tready and reload, giving back-to-back samples with no gap nibble.
- REQ-018 On the last nibble cycle with s_tvalid low, SHALL go to IDLE and set underflow.
- REQ-019 In IDLE, pi_rx_data SHALL be 4'h0.
- REQ-020 pi_rx_samples SHALL be registered as (fifo_level >= BURST), one cycle latency.
- REQ-021 pi_rx_samples SHALL deassert only when fifo_level < BURST; there is no hysteresis.
- REQ-022 The nibble counter SHALL be ceil(log2(SAMPLE_W/4)) bits and wrap to 0 on reload.
- REQ-023 s_tready SHALL never be asserted while s_tvalid is low.
- REQ-024 s_tready SHALL never be asserted more than once per sample period.
- REQ-025 underflow SHALL clear only on reset.

Reset
- REQ-026 While rst_n is low, SHALL force: state=IDLE, shift register=0, counter=0, pi_rx_data=0, s_tready=0, pi_rx_samples=0, underflow=0.
- REQ-027 Reset mid-sample SHALL discard the partial sample; no re-pop occurs after release.
- REQ-028 The first load SHALL occur no earlier than the second clk edge after rst_n deasserts.

Configuration
- REQ-029 With RX_SYNC_NIBBLE_EN defined: SHALL emit the marker nibble 4'hA in a SYNC state before each sample's nibbles, giving SAMPLE_W/4+1 cycles per sample.
- REQ-030 With RX_SYNC_NIBBLE_EN defined: the back-to-back reload SHALL enter SYNC rather than SHIFT.
- REQ-031 Without RX_SYNC_NIBBLE_EN: no SYNC state exists and the sample period is SAMPLE_W/4 cycles.

Structure
- REQ-032 State enum, SYNC_NIBBLE constant (4'hA) and default SAMPLE_W/BURST SHALL live in shared package radioberry_pkg.
- REQ-033 A single sub-module rx_burst_flag (threshold compare and register for pi_rx_samples) SHALL be instantiated; serialization stays in the top.

Verification
- REQ-034 Reset release; FIFO presents 48'h123456_ABCDEF valid -> s_tready pulse once; pi_rx_data = 1,2,3,4,5,6,A,B,C,D,E,F on 12 consecutive cycles; then 0 in IDLE.
- REQ-035 Two samples continuously valid -> second sample's first nibble immediately follows the first sample's 12th nibble; exactly two s_tready pulses 12 cycles apart.
- REQ-036 s_tvalid drops during sample 1 and is low at its last nibble -> underflow=1, state IDLE; underflow stays 1 after s_tvalid returns until rst_n low.
- REQ-037 fifo_level steps 1023->1024->1023 -> pi_rx_samples goes 0->1->0, each change one cycle after the input.
- REQ-038 rst_n pulsed low at nibble 5 -> all outputs 0 immediately; after release, the next sample starts at nibble 0 with one new s_tready.
- REQ-039 RX_SYNC_NIBBLE_EN build, same stimulus as REQ-034 -> A,1,2,...,F over 13 cycles; back-to-back sample spacing 13 cycles.
